// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port.
// Round-robin between ALU and load results, one registered output stage, x0 writes dropped.
module regfile_wb_arbiter #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               alu_valid,
    input  logic [A_WIDTH-1:0] alu_rd,
    input  logic [D_WIDTH-1:0] alu_data,
    output logic               alu_ready,
    input  logic               ld_valid,
    input  logic [A_WIDTH-1:0] ld_rd,
    input  logic [D_WIDTH-1:0] ld_data,
    output logic               ld_ready,
    output logic               RegWrite,
    output logic [A_WIDTH-1:0] rd,
    output logic [D_WIDTH-1:0] write_data3,
    output logic [15:0]        wr_count
);

    logic               rr_ptr;
    logic               xfer;
    logic [A_WIDTH-1:0] sel_rd;
    logic [D_WIDTH-1:0] sel_data;

    // rr_ptr only breaks ties; a lone requester is always granted
    always_comb begin
        alu_ready = rst_n && !hold && alu_valid && (!ld_valid || !rr_ptr);
        ld_ready  = rst_n && !hold && ld_valid  && (!alu_valid || rr_ptr);
        xfer      = alu_ready || ld_ready;
        sel_rd    = ld_ready ? ld_rd   : alu_rd;
        sel_data  = ld_ready ? ld_data : alu_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            RegWrite    <= 1'b0;
            rd          <= '0;
            write_data3 <= '0;
        end else if (xfer) begin
            rr_ptr      <= alu_ready;
            RegWrite    <= (sel_rd != '0);
            rd          <= sel_rd;
            write_data3 <= sel_data;
        end else begin
            RegWrite    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (RegWrite && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level behavioural model,
// plus directed contention, x0, hold, async-reset and saturation scenarios.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data3;
    logic [15:0] wr_count;

    regfile_wb_arbiter #(.A_WIDTH(5), .D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .RegWrite(RegWrite), .rd(rd), .write_data3(write_data3), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: whose turn on a tie, what the write port shows, how many writes so far
    int          m_turn_ld;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_writes;
    bit          m_ga, m_gl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_turn_ld = 0; m_we = 0; m_rd = '0; m_data = '0; m_writes = 0;
    endtask

    // entered just after a negedge; leaves just after the following negedge
    task automatic step(input bit h, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ldat);
        hold = h; alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldat;
        #1;
        m_ga = 0; m_gl = 0;
        if (!h) begin
            if (av && lv) begin
                if (m_turn_ld != 0) m_gl = 1; else m_ga = 1;
            end else if (av) m_ga = 1;
            else if (lv) m_gl = 1;
        end
        check("alu_ready", {31'd0, alu_ready}, {31'd0, m_ga});
        check("ld_ready", {31'd0, ld_ready}, {31'd0, m_gl});
        @(posedge clk);
        if (m_we && m_writes < 65535) m_writes++;
        if (m_ga || m_gl) begin
            m_rd      = m_gl ? lr : ar;
            m_data    = m_gl ? ldat : ad;
            m_we      = (m_rd != 0);
            m_turn_ld = m_ga ? 1 : 0;
        end else begin
            m_we = 0;
        end
        @(negedge clk);
        check("RegWrite", {31'd0, RegWrite}, {31'd0, m_we});
        check("rd", {27'd0, rd}, {27'd0, m_rd});
        check("write_data3", write_data3, m_data);
        check("wr_count", {16'd0, wr_count}, m_writes[31:0]);
    endtask

    // asserts reset between edges, checks immediate clear, releases on a negedge
    task automatic do_reset();
        rst_n = 1'b0;
        alu_valid = 1'b1; ld_valid = 1'b1; hold = 1'b0;
        #1;
        model_reset();
        check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_wd3", write_data3, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        check("rst_readys", {30'd0, alu_ready, ld_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    bit          a_pend, l_pend;
    logic [4:0]  a_r, l_r;
    logic [31:0] a_d, l_d;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // single ALU request
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        check("single_we", {31'd0, RegWrite}, 32'd1);
        check("single_data", write_data3, 32'hDEADBEEF);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("single_count", {16'd0, wr_count}, 32'd1);

        // contention right after reset: ALU first, then load
        do_reset();
        step(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2);
        check("cont0_rd", {27'd0, rd}, 32'd3);
        step(0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2);
        check("cont1_rd", {27'd0, rd}, 32'd4);
        check("cont1_data", write_data3, 32'd2);

        // x0 write accepted but dropped
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
        check("x0_we", {31'd0, RegWrite}, 32'd0);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("x0_count", {16'd0, wr_count}, 32'd2);

        // hold freezes arbitration; load was last granted so ALU resumes
        repeat (3) step(1, 1, 5'd7, 32'd70, 1, 5'd8, 32'd80);
        step(0, 1, 5'd7, 32'd70, 1, 5'd8, 32'd80);
        check("hold_resume_rd", {27'd0, rd}, 32'd7);
        step(0, 0, 5'd7, 32'd70, 1, 5'd8, 32'd80);

        // randomized traffic; requesters keep payload stable until accepted
        a_pend = 0; l_pend = 0;
        a_r = '0; l_r = '0; a_d = '0; l_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1; a_r = 5'($urandom_range(0, 31)); a_d = $urandom;
            end
            if (!l_pend && $urandom_range(0, 2) != 0) begin
                l_pend = 1; l_r = 5'($urandom_range(0, 31)); l_d = $urandom;
            end
            step($urandom_range(0, 4) == 0, a_pend, a_r, a_d, l_pend, l_r, l_d);
            if (m_ga) a_pend = 0;
            if (m_gl) l_pend = 0;
        end

        // async reset while a write is showing, then idle after release
        step(0, 1, 5'd9, 32'hCAFE0009, 0, 5'd0, 32'd0);
        check("pre_rst_we", {31'd0, RegWrite}, 32'd1);
        do_reset();
        repeat (3) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

        // saturation of the write counter
        do_reset();
        hold = 0; alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h5A5A5A5A; ld_valid = 0;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("sat_pre", {16'd0, wr_count}, 32'd65534);
        @(posedge clk);
        @(negedge clk);
        check("sat_hit", {16'd0, wr_count}, 32'h0000FFFF);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sat_stay", {16'd0, wr_count}, 32'h0000FFFF);
        alu_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 5, the register address width.
REQ-002 SHALL have parameter D_WIDTH, default 32, the register data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 hold  input  1  freezes arbitration when 1 (register file write port unavailable).
REQ-006 alu_valid  input  1  ALU writeback request.
REQ-007 alu_rd  input  A_WIDTH  ALU destination register.
REQ-008 alu_data  input  D_WIDTH  ALU result.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 ld_valid  input  1  load writeback request.
REQ-011 ld_rd  input  A_WIDTH  load destination register.
REQ-012 ld_data  input  D_WIDTH  load data.
REQ-013 ld_ready  output  1  load request accepted this cycle.
REQ-014 RegWrite  output  1  registered write enable to register file WE3.
REQ-015 rd  output  A_WIDTH  registered write address to AD3.
REQ-016 write_data3  output  D_WIDTH  registered write data to WD3.
REQ-017 wr_count  output  16  saturating count of committed writes.

Function
REQ-018 A transfer on a requester SHALL occur only in a cycle where its valid and ready are both 1.
REQ-019 Ready outputs SHALL be combinational from valids, hold and rr_ptr; at most one ready SHALL be 1 per cycle.
REQ-020 With hold=1, alu_ready and ld_ready SHALL both be 0.
REQ-021 With hold=0 and exactly one valid, that requester's ready SHALL be 1.
REQ-022 With hold=0 and both valid, grant SHALL go to the requester indicated by the 1-bit round-robin pointer rr_ptr (0=ALU, 1=load).
REQ-023 After every transfer, rr_ptr SHALL point to the requester not granted; without a transfer, rr_ptr SHALL hold.
REQ-024 A ready SHALL be 1 only when the matching valid is 1.
REQ-025 On a transfer, the next cycle SHALL present the granted rd and data on rd and write_data3 (1-cycle latency).
REQ-026 On a transfer, the next cycle SHALL have RegWrite=1 if the granted rd is nonzero, and RegWrite=0 if it is zero (x0 writes dropped but still accepted).
REQ-027 In any cycle without a transfer, the next cycle SHALL have RegWrite=0, and rd and write_data3 SHALL hold their prior values.
REQ-028 wr_count SHALL increment by 1 in each cycle where RegWrite=1, saturating at 16'hFFFF.
REQ-029 A requester SHALL keep valid, rd and data stable until accepted; the arbiter SHALL NOT buffer more than the single output stage.

Reset
REQ-030 While rst_n=0, the block SHALL hold these values regardless of clk:
- RegWrite=0
- rd=0
- write_data3=0
- wr_count=0
- rr_ptr=0 (ALU first)
REQ-031 During reset, the ready outputs SHALL be 0.
REQ-032 A transfer in progress when reset asserts SHALL be discarded, and no write SHALL issue after release until a new transfer occurs.
REQ-033 The first posedge after rst_n rises SHALL operate normally.

Verification
REQ-034 Single request: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF, hold=0 -> alu_ready=1 same cycle; next cycle RegWrite=1, rd=5, write_data3=32'hDEADBEEF; wr_count=1 the cycle after.
REQ-035 Contention after reset: both valid, alu_rd=3/data=1, ld_rd=4/data=2 held for 2 cycles -> cycle 0 ALU granted, cycle 1 load granted; outputs show (3,1) then (4,2) with RegWrite=1 on both.
REQ-036 x0 drop: ld_valid=1, ld_rd=0, ld_data=32'h1234 -> ld_ready=1; next cycle RegWrite=0; wr_count unchanged.
REQ-037 Hold: both valid, hold=1 for 3 cycles -> both readys 0, RegWrite=0, rr_ptr unchanged; hold=0 -> grant resumes at the pointed requester.
REQ-038 Async reset mid-stream: rst_n driven low between clock edges while RegWrite=1 -> RegWrite, rd, write_data3 and wr_count go to 0 immediately; after release with no valids, RegWrite stays 0.
REQ-039 Saturation: force 65536 consecutive ALU writes to rd=1 -> wr_count reaches 16'hFFFF and stays there.
